// File: rtl/inst_sequencer_if.sv
// Host/decoder-facing bus of the instruction sequencer.
// start is a request taken only while busy is low; a start seen while busy is
// dropped, never queued. hold is a stall: while high no opcode is issued.
interface inst_sequencer_if #(
    parameter int ADDR_WIDTH = 4
) ();
    logic                  prog_we;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [15:0]           prog_data;
    logic [ADDR_WIDTH:0]   prog_len;
    logic                  start;
    logic                  hold;
    logic [2:0]            opcode;
    logic                  inst_v;
    logic                  busy;
    logic                  done;

    modport master (
        output prog_we, prog_addr, prog_data, prog_len, start, hold,
        input  opcode, inst_v, busy, done
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len, start, hold,
        output opcode, inst_v, busy, done
    );
endinterface

// File: rtl/inst_sequencer.sv
// Instruction sequencer: runs a small program of repeat-counted words, issuing
// one opcode per cycle to the PE-array decoder, then waits out the decoder's
// write-back pipeline before pulsing done.
module inst_sequencer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DRAIN      = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    inst_sequencer_if.slave     bus,
    output logic [1:0]          dbg_state_o
);
    localparam int LEN_W  = ADDR_WIDTH + 1;
    localparam int DCNT_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e              state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [LEN_W-1:0]    len_q;
    logic [7:0]          rcnt_q;
    logic [DCNT_W-1:0]   dcnt_q;
    logic [3:0]          ir_q;      // {opcode, wb} of the word being issued
    logic [2:0]          opcode_q;
    logic                inst_v_q;
    logic                done_q;
    logic                pc_last;

    // Only {opcode, wb, rpt} are stored; the reserved nibble is dropped.
    logic [11:0]         mem_q [DEPTH];
    logic                unused_rsvd;

    assign unused_rsvd = ^bus.prog_data[3:0];
    assign pc_last     = ({1'b0, pc_q} == (len_q - LEN_W'(1)));

    assign bus.opcode  = opcode_q;
    assign bus.inst_v  = inst_v_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

    // Program store: writable only while idle, deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (bus.prog_we && state_q == S_IDLE) begin
            mem_q[bus.prog_addr] <= bus.prog_data[15:4];
        end
    end

    // Sequencer FSM with registered decoder outputs; outputs default to LOAD/0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            rcnt_q   <= '0;
            dcnt_q   <= '0;
            ir_q     <= '0;
            opcode_q <= 3'b000;
            inst_v_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            opcode_q <= 3'b000;
            inst_v_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.prog_len == '0) begin
                            // Empty program completes immediately without going busy.
                            done_q <= 1'b1;
                        end else begin
                            if (bus.prog_len > LEN_W'(DEPTH)) begin
                                len_q <= LEN_W'(DEPTH);
                            end else begin
                                len_q <= bus.prog_len;
                            end
                            pc_q    <= '0;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    ir_q    <= mem_q[pc_q][11:8];
                    rcnt_q  <= mem_q[pc_q][7:0];
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!bus.hold) begin
                        opcode_q <= ir_q[3:1];
                        inst_v_q <= ir_q[0];
                        if (rcnt_q != 8'd0) begin
                            rcnt_q <= rcnt_q - 8'd1;
                        end else if (!pc_last) begin
                            pc_q    <= pc_q + ADDR_WIDTH'(1);
                            state_q <= S_FETCH;
                        end else begin
                            dcnt_q  <= DCNT_W'(DRAIN - 1);
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // done lands exactly DRAIN cycles after the last issued output.
                    if (dcnt_q != '0) begin
                        dcnt_q <= dcnt_q - DCNT_W'(1);
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: per-cycle traces of {done, busy, inst_v, opcode}
// compared against hand-derived expectations.
module tb_inst_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [5:0] obs   [0:31];
    logic [5:0] exp_t [0:31];

    // Clock and DUT.
    always #5 clk = ~clk;

    inst_sequencer_if #(.ADDR_WIDTH(4)) bus ();

    inst_sequencer #(
        .DEPTH(16),
        .ADDR_WIDTH(4),
        .DRAIN(6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Single comparison point.
    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    endtask

    function automatic logic [15:0] word(input logic [2:0] op, input logic wb, input logic [7:0] rpt);
        return {op, wb, rpt, 4'h0};
    endfunction

    task automatic prog_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    // Cycle 0 carries start; observations are taken mid-cycle before that
    // cycle's stimulus is applied. hold/busy-poke/reset fire in the given cycle.
    task automatic run(input logic [4:0] len, input int hold_cyc, input int poke_cyc,
                       input int rst_cyc, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            obs[k]        = {bus.done, bus.busy, bus.inst_v, bus.opcode};
            bus.start     = (k == 0) || (k == poke_cyc);
            bus.prog_len  = len;
            bus.hold      = (k == hold_cyc);
            bus.prog_we   = (k == poke_cyc);
            bus.prog_addr = 4'd0;
            bus.prog_data = 16'hFFF0;
            rst_n         = (k != rst_cyc);
        end
        bus.start   = 1'b0;
        bus.hold    = 1'b0;
        bus.prog_we = 1'b0;
        rst_n       = 1'b1;
    endtask

    task automatic exp_clear();
        for (int k = 0; k < 32; k++) exp_t[k] = 6'd0;
    endtask

    task automatic exp_issue(input int k, input logic [2:0] op, input logic v);
        exp_t[k][3:0] = {v, op};
    endtask

    task automatic exp_busy(input int a, input int b);
        for (int k = a; k <= b; k++) exp_t[k][4] = 1'b1;
    endtask

    task automatic exp_done(input int k);
        exp_t[k][5] = 1'b1;
    endtask

    task automatic compare(input string name, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            check($sformatf("%s c%0d", name, k), {26'd0, obs[k]}, {26'd0, exp_t[k]});
        end
    endtask

    task automatic expect_single_add();
        exp_clear();
        exp_issue(3, 3'b001, 1'b1);
        exp_issue(4, 3'b001, 1'b1);
        exp_issue(5, 3'b001, 1'b1);
        exp_busy(1, 10);
        exp_done(11);
    endtask

    // Stimulus and final report.
    initial begin
        rst_n         = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.prog_len  = '0;
        bus.start     = 1'b0;
        bus.hold      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {26'd0, bus.done, bus.busy, bus.inst_v, bus.opcode}, 32'd0);
        check("reset state", {30'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;

        // Single word, three issues.
        prog_write(4'd0, word(3'b001, 1'b1, 8'd2));
        run(5'd1, -1, -1, -1, 16);
        expect_single_add();
        compare("single", 16);

        // Two words with a FETCH bubble between them.
        prog_write(4'd0, word(3'b100, 1'b0, 8'd0));
        prog_write(4'd1, word(3'b101, 1'b1, 8'd1));
        run(5'd2, -1, -1, -1, 16);
        exp_clear();
        exp_issue(3, 3'b100, 1'b0);
        exp_issue(5, 3'b101, 1'b1);
        exp_issue(6, 3'b101, 1'b1);
        exp_busy(1, 11);
        exp_done(12);
        compare("two", 16);

        // Hold in cycle 3 delays the remaining issues by one cycle.
        prog_write(4'd0, word(3'b001, 1'b1, 8'd2));
        run(5'd1, 3, -1, -1, 16);
        exp_clear();
        exp_issue(3, 3'b001, 1'b1);
        exp_issue(5, 3'b001, 1'b1);
        exp_issue(6, 3'b001, 1'b1);
        exp_busy(1, 11);
        exp_done(12);
        compare("hold", 16);

        // Zero length: done in cycle 1, never busy.
        run(5'd0, -1, -1, -1, 6);
        exp_clear();
        exp_done(1);
        compare("zero", 6);

        // Write and start while busy are ignored; single done only.
        run(5'd1, -1, 4, -1, 24);
        expect_single_add();
        compare("busy poke", 24);
        run(5'd1, -1, -1, -1, 16);
        expect_single_add();
        compare("rerun", 16);

        // Reset during ISSUE of a 4-repeat word abandons the run.
        prog_write(4'd0, word(3'b010, 1'b1, 8'd3));
        run(5'd1, -1, -1, 4, 16);
        exp_clear();
        exp_issue(3, 3'b010, 1'b1);
        exp_issue(4, 3'b010, 1'b1);
        exp_busy(1, 4);
        compare("mid reset", 16);
        run(5'd1, -1, -1, -1, 16);
        exp_clear();
        for (int k = 3; k <= 6; k++) exp_issue(k, 3'b010, 1'b1);
        exp_busy(1, 11);
        exp_done(12);
        compare("after reset", 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/inst_sequencer.md
# inst_sequencer

Instruction sequencer that sits directly upstream of the PE-array instruction decoder. It holds a small program of compact instruction words, and on `start` issues one 3-bit opcode per cycle together with an instruction-valid/write-back flag. Each word carries its own repeat count, and the block supports a `hold` back-pressure input. After the last issue it waits out the decoder's 6-stage write-back pipeline, then pulses `done`.

## Interface
- `DEPTH`, 16, number of program words.
- `ADDR_WIDTH`, 4, program address width; `DEPTH` = 2^`ADDR_WIDTH`.
- `DRAIN`, 6, cycles to wait after the last issue; equals the decoder's write-back pipeline depth.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `prog_we`  in  1  program write enable.
- `prog_addr`  in  `ADDR_WIDTH`  program write address.
- `prog_data`  in  16  instruction word:
  - [15:13] opcode;
  - [12] wb;
  - [11:4] rpt, issue count minus 1;
  - [3:0] reserved, ignored.
- `prog_len`  in  `ADDR_WIDTH`+1  number of words to run (0..`DEPTH`); sampled only when `start` is accepted.
- `start`  in  1  run request; accepted only in IDLE.
- `hold`  in  1  back-pressure; suppresses issue while high.
- `opcode`  out  3  opcode to the decoder; reset 3'b000 (LOAD).
- `inst_v`  out  1  instruction valid / write-back flag to the decoder; reset 0.
- `busy`  out  1  high while state ≠ IDLE; reset 0.
- `done`  out  1  one-cycle completion pulse; reset 0.

## Operation
- Program memory:
  - `DEPTH`×16 array, written when `prog_we`=1 and state=IDLE.
  - Writes in any other state are ignored.
  - Contents are not cleared by reset.
  - Read is synchronous; the registered word is `ir`.
- State machine: IDLE, FETCH, ISSUE, DRAIN.
- IDLE:
  - `start`=1 and `prog_len`≠0: latch `len`, set `pc`=0, go to FETCH.
  - `start`=1 and `prog_len`=0: stay in IDLE and assert `done` the next cycle.
- FETCH: read mem[`pc`] into `ir`; load `rcnt`=`ir.rpt`; go to ISSUE.
- ISSUE with `hold`=1: no issue; `rcnt` and `pc` are unchanged; remain in ISSUE.
- ISSUE with `hold`=0: issue `ir` once, then:
  - `rcnt`≠0: decrement `rcnt`; stay in ISSUE.
  - `rcnt`=0 and `pc`≠`len`−1: `pc`++; go to FETCH.
  - `rcnt`=0 and `pc`=`len`−1: load `dcnt`=`DRAIN`−1; go to DRAIN.
- DRAIN:
  - `dcnt`≠0: decrement `dcnt`.
  - `dcnt`=0: go to IDLE and set `done`<=1 for exactly one cycle.
- Outputs are registered:
  - On an issue cycle: `opcode`<=`ir.opcode`, `inst_v`<=`ir.wb`.
  - On every other cycle: `opcode`<=3'b000, `inst_v`<=0.
- `wb`=0 words still drive their opcode for one cycle each issue, with `inst_v`=0. They act as configure-only / no-write-back steps.
- Total issue cycles = Σ(`rpt`+1) over words 0..`len`−1. Maximum per word is 256.
- `start` while busy is ignored. `prog_len` > `DEPTH` is clamped to `DEPTH`.
- Reset, including mid-run:
  - Next edge: state=IDLE, `pc`=0, `rcnt`=0, `dcnt`=0.
  - All outputs return to reset values.
  - Any in-flight run is abandoned with no `done`.

## Timing
- `start` accepted at edge of cycle 0:
  - FETCH in cycle 1;
  - ISSUE from cycle 2;
  - first `opcode`/`inst_v` visible in cycle 3.
- Each word after the first costs one FETCH bubble cycle, during which outputs are LOAD/0.
- Each `hold` cycle delays all later issues by exactly one cycle.
- `done` is high exactly `DRAIN` cycles after the last issued output cycle. This aligns with the decoder's `dout_v` for the final write-back.
- `busy` goes high the cycle after `start` is accepted and falls in the same cycle `done` rises.
- `prog_len`=0: `done` is high in cycle 1 and `busy` never rises.

## Test plan
- **Single word, repeats.** Word0 = ADD(001), wb=1, rpt=2, `len`=1, `start` at cycle 0.
  - Required: `opcode`=001 with `inst_v`=1 in cycles 3–5; `done` in cycle 11 only; `busy` high in cycles 1–10.
- **Two words.** Word0 = MUL(100), wb=0, rpt=0; word1 = MULADD(101), wb=1, rpt=1.
  - Required: cycle 3 `opcode`=100 with `inst_v`=0; cycle 4 LOAD/0 (FETCH bubble); cycles 5–6 `opcode`=101 with `inst_v`=1; `done` in cycle 12.
- **Hold.** As the single-word case, with `hold`=1 in cycle 3.
  - Required: outputs in cycle 4 are LOAD/0; the three issues appear in cycles 3, 5, 6; `done` in cycle 12.
- **Zero length.** `start` with `prog_len`=0.
  - Required: `done`=1 in cycle 1; `busy`, `inst_v`, `opcode` remain 0.
- **Writes and start while busy.** During a run, apply `prog_we` to word0 and pulse `start`.
  - Required: memory is unchanged (verified by re-running); the run completes with one `done` only.
- **Reset mid-run.** `rst_n`=0 for one cycle during ISSUE of a 4-repeat word.
  - Required: the next cycle shows `opcode`=000, `inst_v`=0, `busy`=0, with no `done`. A subsequent `start` reruns the retained program with correct timing.
